// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and default width for the arithmetic datapath
package arith_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational one-bit full subtractor x - y - bin
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, start/busy/done framed
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic [CW-1:0]    cnt;
  logic             br, d, bout;
  full_sub_cell u_cell (.x(sa[0]), .y(sb[0]), .bin(br), .d(d), .bout(bout));
  // new bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps
  assign sr_next = (sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else state <= IDLE;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          br  <= bout;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= sr_next;
            borrow_out <= bout;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for WIDTH=8 and an exhaustive WIDTH=1 instance
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, borrow_in;
  logic [7:0] a, b;
  logic       busy, done, borrow_out;
  logic [7:0] diff;
  logic       start1, a1, b1, bi1;
  logic       busy1, done1, diff1, bo1;
  logic       rx, ry, rbin, rd, rbout;
  logic [8:0] q[$];
  logic [1:0] q1[$];
  int         npass = 0;
  int         ntot = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  full_sub_cell ref_cell (.x(rx), .y(ry), .bin(rbin), .d(rd), .bout(rbout));

  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic bi, input bit push);
    logic [8:0] full;
    @(negedge clk);
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    if (push) q.push_back(full);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc = busy ? 1 : 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
    end while (!done && cyc < 40);
  endtask

  task automatic test_reset;
    ntot++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else npass++;
    ntot++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else npass++;
    ntot++; if (diff !== 8'h00) $display("FAIL reset_diff got=%h exp=00", diff); else npass++;
    ntot++; if (borrow_out !== 1'b0) $display("FAIL reset_borrow got=%b exp=0", borrow_out); else npass++;
  endtask

  task automatic test_basic;
    int cyc, bc;
    logic [8:0] exp;
    accept(8'h5A, 8'h3C, 1'b0, 1'b1);
    wait_done(cyc, bc);
    ntot++; if (cyc !== 8) $display("FAIL basic_latency got=%0d exp=8", cyc); else npass++;
    ntot++; if (bc !== 8) $display("FAIL basic_busy_cycles got=%0d exp=8", bc); else npass++;
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL basic_result got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    ntot++; if (diff !== 8'h1E) $display("FAIL basic_const got=%h exp=1e", diff); else npass++;
    @(negedge clk);
    ntot++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else npass++;
  endtask

  task automatic test_borrow;
    int cyc, bc;
    logic [8:0] exp;
    accept(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done(cyc, bc);
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL borrow_underflow got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    accept(8'h10, 8'h10, 1'b1, 1'b1);
    wait_done(cyc, bc);
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL borrow_in_used got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    ntot++; if ({borrow_out, diff} !== 9'h1FF) $display("FAIL borrow_const got=%h exp=1ff", {borrow_out, diff}); else npass++;
  endtask

  task automatic test_start_ignored;
    int cyc, bc, extra;
    logic [8:0] exp;
    accept(8'h20, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'h7F; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    ntot++; if (cyc !== 5) $display("FAIL ignored_latency got=%0d exp=5", cyc); else npass++;
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL ignored_result got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    ntot++; if (extra !== 0) $display("FAIL ignored_extra_done got=%0d exp=0", extra); else npass++;
    ntot++; if (diff !== 8'h1F) $display("FAIL ignored_hold got=%h exp=1f", diff); else npass++;
  endtask

  task automatic test_reset_mid;
    int cyc, bc, extra;
    logic [8:0] exp;
    accept(8'h40, 8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ntot++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else npass++;
    ntot++; if (diff !== 8'h00) $display("FAIL midrst_diff got=%h exp=00", diff); else npass++;
    ntot++; if (borrow_out !== 1'b0) $display("FAIL midrst_borrow got=%b exp=0", borrow_out); else npass++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    ntot++; if (extra !== 0) $display("FAIL midrst_done got=%0d exp=0", extra); else npass++;
    accept(8'h03, 8'h05, 1'b0, 1'b1);
    wait_done(cyc, bc);
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL midrst_next got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
  endtask

  task automatic test_back_to_back;
    int cyc, bc, gap;
    logic [8:0] exp;
    @(negedge clk);
    a = 8'h80; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    q.push_back({1'b0, 8'h80} - {1'b0, 8'h01});
    @(negedge clk);
    wait_done(cyc, bc);
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL b2b_first got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    a = 8'h01; b = 8'h80;
    q.push_back({1'b0, 8'h01} - {1'b0, 8'h80});
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    gap = cyc + 1;
    ntot++; if (gap !== 9) $display("FAIL b2b_gap got=%0d exp=9", gap); else npass++;
    exp = q.pop_front();
    ntot++; if ({borrow_out, diff} !== exp) $display("FAIL b2b_second got=%h exp=%h", {borrow_out, diff}, exp); else npass++;
    ntot++; if ({borrow_out, diff} !== 9'h181) $display("FAIL b2b_const got=%h exp=181", {borrow_out, diff}); else npass++;
  endtask

  task automatic test_width1;
    logic [1:0] exp;
    logic [1:0] arith;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a1, b1, bi1} = 3'(i);
      {rx, ry, rbin} = 3'(i);
      start1 = 1'b1;
      #1;
      q1.push_back({rbout, rd});
      arith = {1'b0, rx} - {1'b0, ry} - {1'b0, rbin};
      ntot++; if ({rbout, rd} !== arith) $display("FAIL w1_cell_%0d got=%b exp=%b", i, {rbout, rd}, arith); else npass++;
      @(negedge clk);
      start1 = 1'b0;
      ntot++; if (busy1 !== 1'b1 || done1 !== 1'b0) $display("FAIL w1_run_%0d busy=%b done=%b exp busy=1 done=0", i, busy1, done1); else npass++;
      @(negedge clk);
      ntot++; if (done1 !== 1'b1) $display("FAIL w1_done_%0d got=%b exp=1", i, done1); else npass++;
      exp = q1.pop_front();
      ntot++; if ({bo1, diff1} !== exp) $display("FAIL w1_result_%0d got=%b exp=%b", i, {bo1, diff1}, exp); else npass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    rx = 1'b0; ry = 1'b0; rbin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_basic;
    test_borrow;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    test_width1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
